// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer and the game-control FSM.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  localparam int DEF_STABLE_SAMPLES = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Board-side button bus: divided-clock level and raw pads in, debounced level and strobes out.
interface btn_debounce_if #(
  parameter int N_BTN = 5
);
  logic             tick_clk;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output tick_clk, btn_raw,
    input  btn_level, btn_press, btn_release
  );

  modport slave (
    input  tick_clk, btn_raw,
    output btn_level, btn_press, btn_release
  );
endinterface

// File: rtl/btn_fsm.sv
// One button's debounce FSM with registered level/press/release outputs.
// Optional auto-repeat of the press strobe while held: DEBOUNCE_REPEAT_EN.
//   state     | meaning
//   IDLE      | released, level 0
//   PRESS_CHK | counting consecutive 1 samples
//   HELD      | pressed, level 1
//   REL_CHK   | counting consecutive 0 samples
module btn_fsm
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sample_en,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int            CW       = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] C_STABLE = CW'(STABLE_SAMPLES);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  btn_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_level, w_level_nxt;
  logic          r_press, w_press_nxt;
  logic          r_release, w_release_nxt;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int            RW          = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RW-1:0] C_REP_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] C_REP_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] C_REP_ONE   = RW'(1);

  // Down-counter preloaded with the first-repeat delay; it idles at that value outside HELD/REL_CHK.
  logic [RW-1:0] r_rep_tmr, w_rep_nxt;
`endif

  assign w_cnt_inc = r_cnt + C_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_rep_tmr <= C_REP_DELAY;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
`ifdef DEBOUNCE_REPEAT_EN
      r_rep_tmr <= w_rep_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    w_rep_nxt     = r_rep_tmr;
`endif
    if (i_sample_en) begin
      case (r_state)
        IDLE: begin
          if (i_btn) begin
            if (STABLE_SAMPLES == 1) begin
              w_state_nxt = HELD;
              w_level_nxt = 1'b1;
              w_press_nxt = 1'b1;
            end else begin
              w_state_nxt = PRESS_CHK;
              w_cnt_nxt   = C_ONE;
            end
          end
        end
        PRESS_CHK: begin
          if (!i_btn) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == C_STABLE) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HELD: begin
          if (!i_btn) begin
            if (STABLE_SAMPLES == 1) begin
              w_state_nxt   = IDLE;
              w_level_nxt   = 1'b0;
              w_release_nxt = 1'b1;
            end else begin
              w_state_nxt = REL_CHK;
              w_cnt_nxt   = C_ONE;
            end
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (r_rep_tmr <= C_REP_ONE) begin
            w_press_nxt = 1'b1;
            w_rep_nxt   = C_REP_RATE;
          end else begin
            w_rep_nxt = r_rep_tmr - C_REP_ONE;
          end
`endif
        end
        REL_CHK: begin
          if (i_btn) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == C_STABLE) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
`ifdef DEBOUNCE_REPEAT_EN
      if (w_state_nxt == IDLE) w_rep_nxt = C_REP_DELAY;
`endif
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes the 500 Hz tick and raw pads, one btn_fsm per button.
// Auto-repeat of press strobes is compiled in with DEBOUNCE_REPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN          = 5,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_RATE    = 50
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);

  if (STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("btn_debounce: STABLE_SAMPLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic             r_tick_s1, r_tick_s2, r_tick_hist;
  logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
  logic             w_sample_en;
  logic [N_BTN-1:0] w_level, w_press, w_release;

  // tick_clk is data from another domain; only its synchronized rising edge is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_s1   <= 1'b0;
      r_tick_s2   <= 1'b0;
      r_tick_hist <= 1'b0;
      r_btn_s1    <= '0;
      r_btn_s2    <= '0;
    end else begin
      r_tick_s1   <= bus.tick_clk;
      r_tick_s2   <= r_tick_s1;
      r_tick_hist <= r_tick_s2;
      r_btn_s1    <= bus.btn_raw;
      r_btn_s2    <= r_btn_s1;
    end
  end

  assign w_sample_en = r_tick_s2 & ~r_tick_hist;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_fsm #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
`endif
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .i_sample_en(w_sample_en),
      .i_btn      (r_btn_s2[gi]),
      .o_level    (w_level[gi]),
      .o_press    (w_press[gi]),
      .o_release  (w_release[gi])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected strobes, a monitor pops on each strobe.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(5)) bus ();

  btn_debounce #(
    .N_BTN         (5),
    .STABLE_SAMPLES(4),
    .REPEAT_DELAY  (3),
    .REPEAT_RATE   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int tick;
    int btn;
    bit press;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rise_cyc = 0;
  int  rises = 0;
  int  sen_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && dut.w_sample_en) sen_cnt++;
  end

  task automatic expect_ev(input int tick, input int btn, input bit press);
    ev_t e;
    e.tick  = tick;
    e.btn   = btn;
    e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int b, input bit p);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe btn=%0d press=%0d tick=%0d (none expected)", b, p, rises);
    end else begin
      e = exp_q.pop_front();
      if (e.btn != b || e.press != p || e.tick != rises || (cyc - rise_cyc) != 3) begin
        errors++;
        $display("FAIL strobe got btn=%0d press=%0d tick=%0d lat=%0d, want btn=%0d press=%0d tick=%0d lat=3",
                 b, p, rises, cyc - rise_cyc, e.btn, e.press, e.tick);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 5; b++) begin
        if (bus.btn_press[b])   check_ev(b, 1'b1);
        if (bus.btn_release[b]) check_ev(b, 1'b0);
      end
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One sample period: pads settle during the low half, the rising edge is the sample point.
  task automatic do_sample(input logic [4:0] v);
    bus.btn_raw  = v;
    bus.tick_clk = 1'b0;
    repeat (10) @(negedge clk);
    bus.tick_clk = 1'b1;
    rises++;
    rise_cyc = cyc;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_samples(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) do_sample(v);
  endtask

  initial begin
    int base;
    logic [4:0] bounce [8];
    rst          = 1'b1;
    bus.tick_clk = 1'b0;
    bus.btn_raw  = 5'b00000;
    repeat (5) @(negedge clk);
    check_val("reset_outputs", int'({bus.btn_level, bus.btn_press, bus.btn_release}), 0);
    rst = 1'b0;

    // idle ticks: one sample_en per rising edge, nothing reported
    run_samples(5'b00000, 10);
    check_val("sample_en_per_tick", sen_cnt, 10);
    check_val("idle_level", int'(bus.btn_level), 0);

    // btn0 press accepted on 4th sample
    expect_ev(rises + 4, 0, 1'b1);
    run_samples(5'b00001, 3);
    check_val("press0_before_4th", int'(bus.btn_level), 0);
    do_sample(5'b00001);
    check_val("press0_level", int'(bus.btn_level), 5'b00001);

    // release with a 2-sample glitch back to 1 inside REL_CHK
    expect_ev(rises + 8, 0, 1'b0);
    do_sample(5'b00000);
    do_sample(5'b00000);
    do_sample(5'b00001);
    do_sample(5'b00001);
    run_samples(5'b00000, 3);
    check_val("rel0_after_glitch_still_held", int'(bus.btn_level[0]), 1);
    do_sample(5'b00000);
    check_val("rel0_level", int'(bus.btn_level), 0);

    // btn1 bouncing with 1-sample widths
    bounce = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 8; i++) do_sample(bounce[i]);
    check_val("bounce1_level", int'(bus.btn_level), 0);

    // 3-sample glitch is one short of acceptance
    run_samples(5'b00010, 3);
    run_samples(5'b00000, 2);
    check_val("glitch3_level", int'(bus.btn_level), 0);

    // tick stuck high: pad changes are not sampled
    bus.btn_raw = 5'b10000;
    repeat (60) @(negedge clk);
    check_val("stuck_tick_level", int'(bus.btn_level), 0);
    check_val("stuck_tick_sample_en", sen_cnt, rises);

    // btn2: press, reset while held, fresh press after reset
    expect_ev(rises + 4, 2, 1'b1);
    run_samples(5'b00100, 4);
    check_val("press2_level", int'(bus.btn_level), 5'b00100);
    rst = 1'b1;
    #1;
    check_val("rst_async_outputs", int'({bus.btn_level, bus.btn_press, bus.btn_release}), 0);
    repeat (3) @(negedge clk);
    bus.tick_clk = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_hold_outputs", int'({bus.btn_level, bus.btn_press, bus.btn_release}), 0);
    rst = 1'b0;
    expect_ev(rises + 4, 2, 1'b1);
    run_samples(5'b00100, 3);
    check_val("repress2_before_4th", int'(bus.btn_level), 0);
    do_sample(5'b00100);
    check_val("repress2_level", int'(bus.btn_level), 5'b00100);
    expect_ev(rises + 4, 2, 1'b0);
    run_samples(5'b00000, 4);
    check_val("rel2_level", int'(bus.btn_level), 0);

    // simultaneous press/release on btn0 and btn4
    expect_ev(rises + 4, 0, 1'b1);
    expect_ev(rises + 4, 4, 1'b1);
    run_samples(5'b10001, 4);
    check_val("simul_level", int'(bus.btn_level), 5'b10001);
    expect_ev(rises + 4, 0, 1'b0);
    expect_ev(rises + 4, 4, 1'b0);
    run_samples(5'b00000, 4);

    // btn3 held 12 samples after acceptance
    expect_ev(rises + 4, 3, 1'b1);
    run_samples(5'b01000, 4);
    base = rises;
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 3; k <= 11; k += 2) expect_ev(base + k, 3, 1'b1);
`endif
    run_samples(5'b01000, 6);
    check_val("hold3_mid_level", int'(bus.btn_level), 5'b01000);
    run_samples(5'b01000, 6);
    check_val("hold3_end_level", int'(bus.btn_level), 5'b01000);
    expect_ev(rises + 4, 3, 1'b0);
    run_samples(5'b00000, 4);
    check_val("rel3_level", int'(bus.btn_level), 0);

    repeat (30) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);
    check_val("sample_en_total", sen_cnt, rises);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and edge-detects the push-button inputs of the game board using the 500 Hz divided clock as its sample timebase. It synchronizes both the divided-clock level and the raw buttons into the 100 MHz domain. It samples the buttons once per divided-clock rising edge and reports a stable level plus one-cycle press and release strobes per button. It sits between the board pins and the game-control FSM, downstream of the clock divider.

## Interface
Parameters:
- N_BTN, 5 — number of buttons.
- STABLE_SAMPLES, 4 — consecutive equal samples required to accept a change (≥1); 8 ms at 500 Hz.
- REPEAT_DELAY, 250 — samples held before first auto-repeat (only with DEBOUNCE_REPEAT_EN).
- REPEAT_RATE, 50 — samples between subsequent auto-repeats (only with DEBOUNCE_REPEAT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- tick_clk  in  1  divided-clock level (50 % duty) from the clock divider; treated as asynchronous data, never used as a clock.
- btn_raw  in  N_BTN  raw pad levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-clk pulse per accepted press (and per auto-repeat).
- btn_release  out  N_BTN  one-clk pulse per accepted release.

## Operation
- tick_clk passes through a 2-FF synchronizer plus one history FF. sample_en = sync2 & ~hist: one-clk pulse per tick_clk rising edge. Falling edges are ignored.
- Each btn_raw bit passes through its own 2-FF synchronizer. The per-button FSM reads only sync2 and acts only on sample_en cycles.
- Per-button FSM, counter cnt of width $clog2(STABLE_SAMPLES+1):
  - IDLE (level 0): sample 1 → PRESS_CHK, cnt=1. If STABLE_SAMPLES==1, go directly to HELD.
  - PRESS_CHK: sample 1 → cnt+1. When cnt reaches STABLE_SAMPLES → HELD, level←1, press pulse. Sample 0 → IDLE, cnt=0.
  - HELD (level 1): sample 0 → REL_CHK, cnt=1.
  - REL_CHK: sample 0 → cnt+1. When cnt reaches STABLE_SAMPLES → IDLE, level←0, release pulse. Sample 1 → HELD, cnt=0.
- Glitches shorter than STABLE_SAMPLES samples never change btn_level and never produce a pulse.
- Buttons are fully independent. Simultaneous presses on several bits produce pulses in the same cycle.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0. All FSMs in IDLE, all synchronizers and counters 0.
- tick_clk rising edge → sample_en asserted in the clk cycle following the second clk edge after the change (2-cycle synchronizer latency).
- Outputs are registered. btn_level changes, and its press/release pulse fires, in the cycle after the sample_en of the STABLE_SAMPLES-th consecutive equal sample. The pulse is exactly 1 clk wide.
- btn_raw changes between samples are invisible. Only the synchronized value on sample_en cycles counts.
- Reset mid-operation clears everything immediately. A button held through reset release is reported as a fresh press after STABLE_SAMPLES samples. No pulse is emitted by reset itself.
- tick_clk stuck at either level: no sample_en, all outputs hold their current values.

## Configuration
- DEBOUNCE_REPEAT_EN defined: HELD carries a repeat counter, cleared on entry to HELD. After REPEAT_DELAY samples in HELD, btn_press pulses again, then again every REPEAT_RATE samples. The counter freezes while in REL_CHK and is cleared on leaving HELD/REL_CHK for IDLE. btn_level is unaffected.
- Not defined: no repeat counter in the netlist. btn_press fires once per accepted press. REPEAT_* parameters are ignored.

## Structure
- Package btn_pkg: state typedef (IDLE, PRESS_CHK, HELD, REL_CHK) and a default STABLE_SAMPLES constant shared with the game-control FSM.
- Sub-module btn_fsm: one button's FSM, counter and optional repeat logic. It is instantiated N_BTN times in a generate loop. The top holds the tick synchronizer/edge detector and the button synchronizers.

## Test plan
Bench parameters: STABLE_SAMPLES=4; tick_clk toggles every 10 clk (one sample per 20 clk); REPEAT_DELAY=3, REPEAT_RATE=2.
- Reset with btn_raw=5'b00000, 10 ticks → all outputs 0, and exactly one sample_en per tick rising edge.
- btn_raw[0] goes 1 and holds → btn_level[0]=1 and a single 1-clk btn_press[0] one cycle after the 4th sample; no release.
- btn_raw[1] bounces 1,0,1,0,1 with 1-sample widths, then settles at 0 → btn_level[1] stays 0, no pulses.
- Release of btn_raw[0] after acceptance, plus a 2-sample 1-glitch during REL_CHK → count restarts; release pulse only after 4 consecutive 0 samples.
- Assert rst while btn_raw[2]=1 in HELD, deassert while still held → outputs 0 during reset; press pulse again 4 samples after release of rst.
- DEBOUNCE_REPEAT_EN, hold btn_raw[3] for 12 samples after acceptance → btn_press[3] at acceptance, then at samples 3, 5, 7, 9, 11 of HELD; level stays 1 throughout.
